soc_pio_ctrl: RTL



---
 rtl/soc_pio_pkg.sv | 18 +
 rtl/soc_pio_if.sv | 21 ++
 rtl/soc_pio_sync.sv | 26 ++
 rtl/soc_pio_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/soc_pio_pkg.sv
// Shared constants for the soc_pio GPIO bank: register map, capture modes,
// bus address width.
package soc_pio_pkg;

   localparam int ADDR_W = 3;

   localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_DIR      = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
   localparam logic [ADDR_W-1:0] ADDR_OUTCLR   = 3'd5;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/soc_pio_if.sv
// Avalon-MM slave bus bundle used by the soc_pio GPIO bank.
interface soc_pio_if;
   import soc_pio_pkg::*;

   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [31:0]       writedata;
   logic [31:0]       readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/soc_pio_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous pin inputs, reset to 0.
module soc_pio_sync #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] chain_r [STAGES];

   // Shift the pin value through the synchroniser chain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < STAGES; i++) chain_r[i] <= '0;
      end else begin
         chain_r[0] <= d;
         for (int i = 1; i < STAGES; i++) chain_r[i] <= chain_r[i-1];
      end
   end

   assign q = chain_r[STAGES-1];

endmodule

// File: rtl/soc_pio_ctrl.sv
// Avalon-MM parallel I/O controller: per-bit direction, atomic set/clear,
// synchronised edge capture and a maskable level interrupt.
module soc_pio_ctrl
   import soc_pio_pkg::*;
#(
   parameter int                DATA_W      = 8,
   parameter logic [DATA_W-1:0] OUT_RESET   = '0,
   parameter logic [DATA_W-1:0] DIR_RESET   = '1,
   parameter int                SYNC_STAGES = 2,
   parameter int                EDGE_TYPE   = EDGE_RISE
) (
   input  logic              clk,
   input  logic              reset_n,
   soc_pio_if.slave          bus,
   input  logic [DATA_W-1:0] in_port,
   output logic [DATA_W-1:0] out_port,
   output logic [DATA_W-1:0] out_oe,
   output logic              irq
);

   localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

   logic [DATA_W-1:0] data_out_r, dir_r, irq_mask_r, edge_cap_r, prev_r;
   logic [DATA_W-1:0] data_out_nxt_s, dir_nxt_s, irq_mask_nxt_s, w1c_s;
   logic [DATA_W-1:0] in_sync_s, wdata_s, rise_s, fall_s, edge_s, rd_s;
   logic [2:0]        prime_cnt_r;
   logic              prime_done_s, wr_s, unused_wdata_s;

   soc_pio_sync #(.WIDTH(DATA_W), .STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (in_port),
      .q       (in_sync_s)
   );

   assign wr_s           = bus.chipselect & ~bus.write_n;
   assign wdata_s        = bus.writedata[DATA_W-1:0];
   assign unused_wdata_s = ^bus.writedata;
   assign prime_done_s   = (prime_cnt_r == PRIME_MAX);
   assign rise_s         = in_sync_s & ~prev_r;
   assign fall_s         = ~in_sync_s & prev_r;

   // Edge selection, held off until the synchroniser has flushed reset values.
   always_comb begin
      edge_s = '0;
      if (prime_done_s) begin
         case (EDGE_TYPE)
            EDGE_RISE: edge_s = rise_s;
            EDGE_FALL: edge_s = fall_s;
            default:   edge_s = rise_s | fall_s;
         endcase
      end else begin
         edge_s = '0;
      end
   end

   // Register write decode.
   always_comb begin
      data_out_nxt_s = data_out_r;
      dir_nxt_s      = dir_r;
      irq_mask_nxt_s = irq_mask_r;
      w1c_s          = '0;
      if (wr_s) begin
         case (bus.address)
            ADDR_DATA:     data_out_nxt_s = wdata_s;
            ADDR_DIR:      dir_nxt_s      = wdata_s;
            ADDR_IRQ_MASK: irq_mask_nxt_s = wdata_s;
            ADDR_EDGE_CAP: w1c_s          = wdata_s;
            ADDR_OUTSET:   data_out_nxt_s = data_out_r | wdata_s;
            ADDR_OUTCLR:   data_out_nxt_s = data_out_r & ~wdata_s;
            default:       data_out_nxt_s = data_out_r;
         endcase
      end else begin
         w1c_s = '0;
      end
   end

   // Architectural state; a fresh edge overrides a same-cycle clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out_r  <= OUT_RESET;
         dir_r       <= DIR_RESET;
         irq_mask_r  <= '0;
         edge_cap_r  <= '0;
         prev_r      <= '0;
         prime_cnt_r <= 3'd0;
      end else begin
         data_out_r <= data_out_nxt_s;
         dir_r      <= dir_nxt_s;
         irq_mask_r <= irq_mask_nxt_s;
         edge_cap_r <= (edge_cap_r & ~w1c_s) | edge_s;
         prev_r     <= in_sync_s;
         if (!prime_done_s) begin
            prime_cnt_r <= prime_cnt_r + 3'd1;
         end
      end
   end

   // Zero-latency read mux; output bits read back the driven value.
   always_comb begin
      rd_s = '0;
      case (bus.address)
         ADDR_DATA:     rd_s = (dir_r & data_out_r) | (~dir_r & in_sync_s);
         ADDR_DIR:      rd_s = dir_r;
         ADDR_IRQ_MASK: rd_s = irq_mask_r;
         ADDR_EDGE_CAP: rd_s = edge_cap_r;
         default:       rd_s = '0;
      endcase
      bus.readdata = 32'h0000_0000;
      bus.readdata[DATA_W-1:0] = rd_s;
   end

   assign out_port = data_out_r;
   assign out_oe   = dir_r;
   assign irq      = prime_done_s & (|(edge_cap_r & irq_mask_r));

endmodule
